// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word reads to
// instruction memory, buffers in-order responses and hands them to decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic             stale_q, stale_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];

  logic             handshake;
  logic             push;
  logic             pop;
  logic             credit;
  logic [CNT_W:0]   occupancy;
  logic [31:0]      redirect_tgt;

  // Datapath next-state: counters, pointers, PC tracking and discard bookkeeping.
  always_comb begin
    redirect_tgt = redirect_pc & ~32'h0000_0003;
    handshake    = (state_q == ST_REQ) && imem_req_ready;
    push         = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
    pop          = (count_q != '0) && instr_ready && !redirect_valid;

    inflight_d = inflight_q + CNT_W'(handshake) - CNT_W'(imem_rsp_valid);

    stale_d = stale_q;
    if (handshake) begin
      stale_d = 1'b0;
    end
    if (redirect_valid && (state_q == ST_REQ) && !imem_req_ready) begin
      stale_d = 1'b1;
    end

    // On redirect every still-outstanding old-path response must be dropped,
    // including the one belonging to a presented-but-unaccepted request.
    discard_d = discard_q;
    if (imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end
    if (redirect_valid) begin
      discard_d = inflight_d + CNT_W'(stale_d);
    end

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // A stale request carries the old address, so its acceptance leaves pc alone.
    pc_d = pc_q;
    if (handshake && !stale_q) begin
      pc_d = pc_q + 32'd4;
    end
    if (redirect_valid) begin
      pc_d = redirect_tgt;
    end

    if ((state_q == ST_REQ) && !imem_req_ready) begin
      req_addr_d = req_addr_q;
    end else begin
      req_addr_d = pc_d;
    end

    rsp_pc_d = rsp_pc_q;
    if (push) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (redirect_valid) begin
      rsp_pc_d = redirect_tgt;
    end

    occupancy = {1'b0, inflight_d} + {1'b0, count_d};
    credit    = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  end

  // Request FSM: a new request is only presented once a buffer slot is reserved.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (credit) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (handshake) begin
          state_d = credit ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      stale_q    <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      rsp_pc_q   <= rsp_pc_d;
      stale_q    <= stale_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
      fifo_data_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_comb begin
    imem_req_valid = (state_q == ST_REQ);
    imem_req_addr  = req_addr_q;
    instr_valid    = (count_q != '0);
    instruction    = instr_valid ? fifo_data_q[rd_ptr_q] : NOP;
    instr_pc       = instr_valid ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: random memory/decode/redirect stimulus
// against a queue-based model of outstanding requests and the decode buffer.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] addr; int rt; bit wrong; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        mq[$];
  ent_t        mfifo[$];
  logic [31:0] popped[$];
  logic [31:0] m_pc;
  bit          m_stale;
  bit          prev_held;
  logic [31:0] prev_addr;
  int          idle_run;

  int checks, errors, cyc, pop_cnt;
  int first_hs, first_iv;
  logic [31:0] first_hs_addr;

  int cfg_ready_pct, cfg_iready_pct, cfg_lat_max, cfg_redir_pm;
  bit do_redirect, redir_when_valid;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mfifo.delete();
    popped.delete();
    m_pc      = 32'h0000_0000;
    m_stale   = 1'b0;
    prev_held = 1'b0;
    idle_run  = 0;
  endtask

  // One clock: compare outputs, drive next inputs, then advance the model.
  task automatic cycle();
    logic v, iv, hs, redir;
    logic [31:0] a, rtgt;
    req_t e;
    ent_t f;
    int lat, rt;
    @(negedge clk);
    v  = imem_req_valid;
    a  = imem_req_addr;
    iv = instr_valid;
    chk("instr_valid", 32'(iv), 32'(mfifo.size() != 0));
    if (mfifo.size() != 0) begin
      chk("instr_pc", instr_pc, mfifo[0].pc);
      chk("instruction", instruction, mfifo[0].data);
    end else begin
      chk("idle_instruction", instruction, NOP);
      chk("idle_instr_pc", instr_pc, 32'h0);
    end
    if (prev_held) begin
      chk("hold_valid", 32'(v), 32'd1);
      chk("hold_addr", a, prev_addr);
    end
    if (v && !m_stale) chk("req_addr", a, m_pc);
    chk("credit_bound", 32'((mq.size() + mfifo.size()) <= DEPTH), 32'd1);
    if (!v && mq.size() == 0 && mfifo.size() == 0) idle_run++; else idle_run = 0;
    chk("idle_stall", 32'(idle_run <= 2), 32'd1);

    imem_req_ready = ($urandom_range(99) < cfg_ready_pct);
    instr_ready    = ($urandom_range(99) < cfg_iready_pct);
    redir = 1'b0;
    rtgt  = 32'h0;
    if (do_redirect || (redir_when_valid && v)) begin
      redir = 1'b1;
      rtgt  = redir_target;
      do_redirect      = 1'b0;
      redir_when_valid = 1'b0;
    end else if ($urandom_range(999) < cfg_redir_pm) begin
      redir = 1'b1;
      case ($urandom_range(2))
        0:       rtgt = $urandom;
        1:       rtgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        default: rtgt = 32'($urandom_range(255));
      endcase
    end
    redirect_valid = redir;
    redirect_pc    = redir ? rtgt : $urandom;
    if (mq.size() != 0 && mq[0].rt <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    hs = v && imem_req_ready;
    if (hs && first_hs < 0) begin
      first_hs      = cyc;
      first_hs_addr = a;
    end
    if (iv && first_iv < 0) first_iv = cyc;

    if (iv && instr_ready && !redir) begin
      popped.push_back(instr_pc);
      pop_cnt++;
      if (mfifo.size() != 0) void'(mfifo.pop_front());
    end
    if (imem_rsp_valid) begin
      e = mq.pop_front();
      if (!e.wrong && !redir) begin
        f.pc   = e.addr;
        f.data = mem_word(e.addr);
        mfifo.push_back(f);
      end
    end
    if (hs) begin
      lat = $urandom_range(cfg_lat_max, 1);
      rt  = cyc + lat;
      if (mq.size() != 0 && rt <= mq[mq.size()-1].rt) rt = mq[mq.size()-1].rt + 1;
      e.addr  = a;
      e.rt    = rt;
      e.wrong = m_stale;
      mq.push_back(e);
      if (!m_stale) m_pc = m_pc + 32'd4;
      m_stale = 1'b0;
    end
    if (redir) begin
      mfifo.delete();
      foreach (mq[i]) mq[i].wrong = 1'b1;
      m_pc = rtgt & ~32'h3;
      if (v && !imem_req_ready) m_stale = 1'b1;
      popped.delete();
    end
    prev_held = v && !imem_req_ready;
    prev_addr = a;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instruction"}, instruction, NOP);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k;
    k = 0;
    while (popped.size() < n && k < 60) begin
      cycle();
      k++;
    end
    if (popped.size() < n) begin
      errors++;
      $display("FAIL %s timeout got %0d pops want %0d", tag, popped.size(), n);
    end
  endtask

  initial begin
    int k, rand_start;
    checks = 0; errors = 0; cyc = 0; pop_cnt = 0;
    first_hs = -1; first_iv = -1; first_hs_addr = 32'hx;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    cfg_ready_pct = 100; cfg_iready_pct = 100; cfg_lat_max = 1; cfg_redir_pm = 0;
    do_redirect = 1'b0; redir_when_valid = 1'b0; redir_target = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Streaming with ideal memory and decode.
    repeat (30) cycle();
    chk("first_hs_addr", first_hs_addr, 32'h0);
    chk("first_valid_latency", 32'(first_iv - first_hs), 32'd2);
    if (popped.size() >= 3) begin
      chk("pop0_pc", popped[0], 32'h0);
      chk("pop1_pc", popped[1], 32'h4);
      chk("pop2_pc", popped[2], 32'h8);
    end else begin
      errors++;
      $display("FAIL stream_pops got %0d want 3", popped.size());
    end

    // Decode stall: requests must stop once the buffer is reserved.
    cfg_iready_pct = 0;
    repeat (10) cycle();
    chk("stall_req_dropped", 32'(imem_req_valid), 32'd0);
    chk("stall_buffer_full", 32'(instr_valid), 32'd1);
    cfg_iready_pct = 100;
    repeat (10) cycle();

    // Memory stall: presented request held stable.
    cfg_ready_pct = 0;
    repeat (6) cycle();
    cfg_ready_pct = 100;
    repeat (6) cycle();

    // Redirect with requests in flight; low address bits ignored.
    cfg_lat_max = 2;
    repeat (6) cycle();
    redir_target = 32'h0000_0103;
    do_redirect  = 1'b1;
    cycle();
    wait_pops(1, "redirect_0x100");
    if (popped.size() >= 1) chk("redirect_first_pc", popped[0], 32'h100);
    repeat (5) cycle();

    // Redirect while a request is presented but not accepted.
    cfg_lat_max   = 1;
    cfg_ready_pct = 0;
    redir_target  = 32'h0000_0200;
    redir_when_valid = 1'b1;
    k = 0;
    while (redir_when_valid && k < 20) begin
      cycle();
      k++;
    end
    if (redir_when_valid) begin
      errors++;
      $display("FAIL stale_redirect timeout waiting for request");
      redir_when_valid = 1'b0;
    end
    repeat (3) cycle();
    cfg_ready_pct = 100;
    wait_pops(2, "stale_redirect");
    if (popped.size() >= 2) begin
      chk("stale_first_pc", popped[0], 32'h200);
      chk("stale_second_pc", popped[1], 32'h204);
    end

    // Randomized traffic.
    rand_start = pop_cnt;
    for (int blk = 0; blk < 15; blk++) begin
      cfg_ready_pct  = $urandom_range(100, 30);
      cfg_iready_pct = $urandom_range(100, 20);
      cfg_lat_max    = $urandom_range(4, 1);
      cfg_redir_pm   = $urandom_range(40, 0);
      repeat (200) cycle();
    end
    cfg_redir_pm = 0; cfg_ready_pct = 100; cfg_iready_pct = 100;
    repeat (20) cycle();
    chk("random_progress", 32'((pop_cnt - rand_start) >= 200), 32'd1);

    // Asynchronous reset with the buffer full.
    cfg_iready_pct = 0;
    repeat (10) cycle();
    chk("prereset_full", 32'(instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    model_reset();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    rst = 1'b0;
    cfg_iready_pct = 100;
    cfg_lat_max    = 1;
    repeat (20) cycle();
    if (popped.size() >= 2) begin
      chk("post_reset_pc0", popped[0], 32'h0);
      chk("post_reset_pc1", popped[1], 32'h4);
    end else begin
      errors++;
      $display("FAIL post_reset_pops got %0d want 2", popped.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
